// File: rtl/ofm_accum_writer.sv
// rtl/ofm_accum_writer.sv - OFM partial-sum writer: overwrite or read-accumulate-write into the OFM SRAM
// Accumulation saturates each lane to the signed MAC_OUT_BIT range.
module ofm_accum_writer #(
   parameter int SYS_WIDTH   = 8,
   parameter int MAC_OUT_BIT = 24,
   parameter int ADDR_BIT    = 9,
   parameter int LEN_BIT     = 10
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               start,
   input  logic [LEN_BIT-1:0]                 cfg_len,
   input  logic                               psum_valid,
   output logic                               psum_ready,
   input  logic                               psum_first,
   input  logic [ADDR_BIT-1:0]                psum_addr,
   input  logic [SYS_WIDTH-1:0]               psum_mask,
   input  logic [SYS_WIDTH*MAC_OUT_BIT-1:0]   psum_data,
   output logic [ADDR_BIT-1:0]                sram_A,
   output logic [SYS_WIDTH*MAC_OUT_BIT-1:0]   sram_DI,
   output logic [SYS_WIDTH-1:0]               sram_WEB,
   output logic                               sram_OE,
   output logic                               sram_CS,
   input  logic [SYS_WIDTH*MAC_OUT_BIT-1:0]   sram_DO,
   output logic                               busy,
   output logic                               done
);
   localparam int DW = SYS_WIDTH * MAC_OUT_BIT;

   typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;

   state_t                r_state;
   state_t                w_next;
   logic                  w_accept;
   logic [ADDR_BIT-1:0]   r_addr;
   logic [SYS_WIDTH-1:0]  r_mask;
   logic [DW-1:0]         r_data;
   logic                  r_first;
   logic [LEN_BIT-1:0]    r_cnt;
   logic [LEN_BIT-1:0]    r_len;
   logic                  r_done;
   logic [LEN_BIT:0]      w_cnt_inc;
   logic                  w_hit;
   logic [DW-1:0]         w_acc;

   assign w_accept  = psum_valid & psum_ready;
   assign w_cnt_inc = {1'b0, r_cnt} + 1'b1;
   assign w_hit     = (r_len != '0) && (w_cnt_inc == {1'b0, r_len});
   assign done      = r_done;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (w_accept)
         w_next = psum_first ? S_WRITE : S_READ;
      else begin
         case (r_state)
            S_READ:  w_next = S_WRITE;
            S_WRITE: w_next = S_IDLE;
            default: w_next = S_IDLE;
         endcase
      end
   end

   always_comb begin
      psum_ready = 1'b0;
      busy       = 1'b0;
      sram_CS    = 1'b0;
      sram_OE    = 1'b0;
      sram_WEB   = '1;
      sram_A     = '0;
      sram_DI    = '0;
      case (r_state)
         S_READ: begin
            busy    = 1'b1;
            sram_CS = 1'b1;
            sram_OE = 1'b1;
            sram_A  = r_addr;
         end
         S_WRITE: begin
            psum_ready = 1'b1;
            busy       = 1'b1;
            sram_CS    = 1'b1;
            sram_A     = r_addr;
            sram_WEB   = ~r_mask;
            sram_DI    = r_first ? r_data : w_acc;
         end
         default: psum_ready = 1'b1;
      endcase
   end

   // Widen by one bit so the true sum is exact, then clamp on sign disagreement.
   for (genvar g = 0; g < SYS_WIDTH; g++) begin : g_lane
      logic [MAC_OUT_BIT:0] w_sum;
      assign w_sum = {sram_DO[g*MAC_OUT_BIT+MAC_OUT_BIT-1], sram_DO[g*MAC_OUT_BIT +: MAC_OUT_BIT]}
                   + {r_data[g*MAC_OUT_BIT+MAC_OUT_BIT-1], r_data[g*MAC_OUT_BIT +: MAC_OUT_BIT]};
      assign w_acc[g*MAC_OUT_BIT +: MAC_OUT_BIT] =
         (w_sum[MAC_OUT_BIT] != w_sum[MAC_OUT_BIT-1])
            ? (w_sum[MAC_OUT_BIT] ? {1'b1, {(MAC_OUT_BIT-1){1'b0}}} : {1'b0, {(MAC_OUT_BIT-1){1'b1}}})
            : w_sum[MAC_OUT_BIT-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr  <= '0;
         r_mask  <= '0;
         r_data  <= '0;
         r_first <= 1'b0;
      end else if (w_accept) begin
         r_addr  <= psum_addr;
         r_mask  <= psum_mask;
         r_data  <= psum_data;
         r_first <= psum_first;
      end
   end

   // start wins over a same-cycle count so a new tile never inherits a stale write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt  <= '0;
         r_len  <= '0;
         r_done <= 1'b0;
      end else if (start) begin
         r_cnt  <= '0;
         r_len  <= cfg_len;
         r_done <= 1'b0;
      end else if (r_state == S_WRITE) begin
         r_cnt  <= w_hit ? '0 : w_cnt_inc[LEN_BIT-1:0];
         r_done <= w_hit;
      end else begin
         r_done <= 1'b0;
      end
   end
endmodule

// File: tb/tb_ofm_accum_writer.sv
// tb/tb_ofm_accum_writer.sv - randomized bench with SRAM model and transaction-level reference for ofm_accum_writer
// Directed literal cases pin the reference before a random phase.
module tb_ofm_accum_writer;
   localparam int NL = 8;
   localparam int MB = 24;
   localparam int DW = NL * MB;
   localparam int NW = 464;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [9:0]    cfg_len = '0;
   logic          psum_valid = 1'b0;
   logic          psum_ready;
   logic          psum_first = 1'b0;
   logic [8:0]    psum_addr = '0;
   logic [7:0]    psum_mask = '0;
   logic [DW-1:0] psum_data = '0;
   logic [8:0]    sram_A;
   logic [DW-1:0] sram_DI;
   logic [7:0]    sram_WEB;
   logic          sram_OE;
   logic          sram_CS;
   logic [DW-1:0] sram_DO = '0;
   logic          busy;
   logic          done;

   ofm_accum_writer dut (
      .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len),
      .psum_valid(psum_valid), .psum_ready(psum_ready), .psum_first(psum_first),
      .psum_addr(psum_addr), .psum_mask(psum_mask), .psum_data(psum_data),
      .sram_A(sram_A), .sram_DI(sram_DI), .sram_WEB(sram_WEB), .sram_OE(sram_OE),
      .sram_CS(sram_CS), .sram_DO(sram_DO), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // SRAM: synchronous read data one cycle after the read edge, per-lane active-low write.
   logic [DW-1:0] mem    [0:NW-1];
   logic [DW-1:0] golden [0:NW-1];
   always @(posedge clk) begin
      if (sram_CS) begin
         if (sram_OE) sram_DO <= mem[sram_A];
         for (int i = 0; i < NL; i++)
            if (!sram_WEB[i]) mem[sram_A][i*MB +: MB] <= sram_DI[i*MB +: MB];
      end
   end

   function automatic logic [MB-1:0] sat(input logic [MB-1:0] a, input logic [MB-1:0] b);
      int s;
      s = int'($signed(a)) + int'($signed(b));
      if (s > 8388607) s = 8388607;
      else if (s < -8388608) s = -8388608;
      return s[MB-1:0];
   endfunction

   function automatic logic [DW-1:0] acc_word(input logic [DW-1:0] old, input logic [DW-1:0] d);
      logic [DW-1:0] r;
      for (int i = 0; i < NL; i++) r[i*MB +: MB] = sat(old[i*MB +: MB], d[i*MB +: MB]);
      return r;
   endfunction

   function automatic logic [MB-1:0] rnd_lane();
      case ($urandom_range(0, 3))
         0: return MB'($urandom_range(0, 400)) - MB'(200);
         1: return 24'h7FFF00 + MB'($urandom_range(0, 255));
         2: return 24'h800000 + MB'($urandom_range(0, 255));
         default: return MB'($urandom);
      endcase
   endfunction

   function automatic logic [DW-1:0] rnd_word();
      logic [DW-1:0] w;
      for (int i = 0; i < NL; i++) w[i*MB +: MB] = rnd_lane();
      return w;
   endfunction

   // Reference: each accepted transaction expands into the list of cycles it must occupy.
   typedef struct {
      bit            wr;
      bit            first;
      logic [8:0]    addr;
      logic [7:0]    mask;
      logic [DW-1:0] data;
      logic [DW-1:0] di;
   } cyc_t;

   cyc_t q[$];
   bit   m_ready = 1'b1;
   bit   m_done = 1'b0;
   int   m_cnt = 0;
   int   m_len = 0;
   int   done_pulses = 0;

   always @(posedge clk) begin
      cyc_t e;
      bit   wrote;
      #2;
      if (rst) begin
         q.delete();
         m_cnt  = 0;
         m_len  = 0;
         m_done = 1'b0;
      end else begin
         wrote = 1'b0;
         if (q.size() > 0) begin
            e = q.pop_front();
            if (e.wr) begin
               wrote = 1'b1;
               for (int i = 0; i < NL; i++)
                  if (e.mask[i]) golden[e.addr][i*MB +: MB] = e.di[i*MB +: MB];
            end
         end
         if (psum_valid && m_ready) begin
            e.first = psum_first; e.addr = psum_addr; e.mask = psum_mask;
            e.data = psum_data; e.di = '0;
            if (!psum_first) begin
               e.wr = 1'b0;
               q.push_back(e);
            end
            e.wr = 1'b1;
            q.push_back(e);
         end
         if (start) begin
            m_cnt = 0;
            m_len = int'(cfg_len);
            m_done = 1'b0;
         end else if (wrote) begin
            m_cnt++;
            m_done = (m_len != 0) && (m_cnt == m_len);
            if (m_done) m_cnt = 0;
         end else begin
            m_done = 1'b0;
         end
      end
      if (q.size() == 0) begin
         chk("idle_ctl", {sram_CS, sram_OE, sram_WEB, sram_A}, {1'b0, 1'b0, 8'hFF, 9'd0});
         chk("idle_di", sram_DI, '0);
      end else if (!q[0].wr) begin
         chk("read_ctl", {sram_CS, sram_OE, sram_WEB, sram_A}, {1'b1, 1'b1, 8'hFF, q[0].addr});
      end else begin
         q[0].di = q[0].first ? q[0].data : acc_word(golden[q[0].addr], q[0].data);
         chk("write_ctl", {sram_CS, sram_OE, sram_WEB, sram_A}, {1'b1, 1'b0, ~q[0].mask, q[0].addr});
         chk("write_di", sram_DI, q[0].di);
      end
      m_ready = (q.size() == 0) || q[0].wr;
      chk("ready", psum_ready, m_ready);
      chk("busy", busy, q.size() != 0);
      chk("done", done, m_done);
      if (done) done_pulses++;
   end

   bit rdy_log[$];

   task automatic send(input bit f, input logic [8:0] a, input logic [7:0] m, input logic [DW-1:0] d);
      bit got = 1'b0;
      psum_valid = 1'b1; psum_first = f; psum_addr = a; psum_mask = m; psum_data = d;
      for (int k = 0; k < 20 && !got; k++) begin
         rdy_log.push_back(psum_ready);
         got = psum_ready;
         @(negedge clk);
      end
      psum_valid = 1'b0;
      if (!got) chk("accept_timeout", 1'b0, 1'b1);
   endtask

   task automatic idle(input int n);
      psum_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      logic [DW-1:0] w;
      logic [DW-1:0] saved;
      int            p0;
      int            nmis;
      for (int a = 0; a < NW; a++) begin
         mem[a]    = rnd_word();
         golden[a] = mem[a];
      end
      chk("sat_model_pos", sat(24'h7FFFF0, 24'h000020), 24'h7FFFFF);
      chk("sat_model_neg", sat(24'h800010, 24'hFFFFE0), 24'h800000);

      repeat (3) @(negedge clk);
      chk("reset_outs", {busy, done, psum_ready, sram_CS, sram_WEB}, {1'b0, 1'b0, 1'b1, 1'b0, 8'hFF});
      rst = 1'b0;

      // Overwrite right after reset release.
      for (int i = 0; i < NL; i++) w[i*MB +: MB] = MB'(i + 1);
      rdy_log.delete();
      send(1'b1, 9'd5, 8'hFF, w);
      chk("first_accept_1cyc", 32'(rdy_log.size()), 32'd1);
      chk("ovw_ctl", {sram_CS, sram_WEB, sram_A}, {1'b1, 8'h00, 9'd5});
      chk("ovw_di", sram_DI, {24'd8, 24'd7, 24'd6, 24'd5, 24'd4, 24'd3, 24'd2, 24'd1});
      @(negedge clk);
      chk("ovw_then_idle", busy, 1'b0);

      // Accumulate: 100 + (-30).
      w = '0; w[23:0] = 24'd100;
      send(1'b1, 9'd5, 8'h01, w);
      w[23:0] = 24'hFFFFE2;
      send(1'b0, 9'd5, 8'h01, w);
      chk("acc_read_ctl", {sram_WEB, sram_OE, sram_CS}, {8'hFF, 1'b1, 1'b1});
      @(negedge clk);
      chk("acc_write_lane0", sram_DI[23:0], 24'd70);
      chk("acc_write_web", sram_WEB, 8'hFE);
      idle(1);

      // Saturation both directions.
      w = '0; w[23:0] = 24'h7FFFF0; w[47:24] = 24'h800010;
      send(1'b1, 9'd7, 8'h03, w);
      w = '0; w[23:0] = 24'h000020; w[47:24] = 24'hFFFFE0;
      send(1'b0, 9'd7, 8'h03, w);
      @(negedge clk);
      chk("sat_pos", sram_DI[23:0], 24'h7FFFFF);
      chk("sat_neg", sram_DI[47:24], 24'h800000);
      chk("sat_web", sram_WEB, 8'hFC);
      idle(1);

      // Partial mask.
      send(1'b0, 9'd20, 8'h0F, rnd_word());
      @(negedge clk);
      chk("mask_web", sram_WEB, 8'hF0);
      idle(1);

      // Two back-to-back accumulates to one address.
      w = '0; w[23:0] = 24'd10;
      send(1'b1, 9'd9, 8'h01, w);
      idle(1);
      rdy_log.delete();
      w[23:0] = 24'd5;
      send(1'b0, 9'd9, 8'h01, w);
      w[23:0] = 24'd7;
      send(1'b0, 9'd9, 8'h01, w);
      rdy_log.push_back(psum_ready);
      chk("ready_pattern", {28'd0, rdy_log.size() == 4 ? {rdy_log[0], rdy_log[1], rdy_log[2], rdy_log[3]} : 4'hF},
          32'h0000000A);
      idle(3);
      chk("b2b_final", mem[9][23:0], 24'd22);

      // Done after the third write of a tile, not after a fourth.
      start = 1'b1; cfg_len = 10'd3;
      @(negedge clk);
      start = 1'b0;
      p0 = done_pulses;
      send(1'b1, 9'd30, 8'hFF, rnd_word());
      send(1'b1, 9'd31, 8'hFF, rnd_word());
      send(1'b1, 9'd32, 8'h00, rnd_word());
      chk("done_not_early", done, 1'b0);
      @(negedge clk);
      chk("done_pulse", done, 1'b1);
      @(negedge clk);
      chk("done_one_cycle", done, 1'b0);
      send(1'b1, 9'd33, 8'hFF, rnd_word());
      idle(3);
      chk("done_count", 32'(done_pulses - p0), 32'd1);

      // Reset while an accumulate is in its read cycle.
      saved = mem[11];
      send(1'b0, 9'd11, 8'hFF, rnd_word());
      chk("rst_pre_busy", busy, 1'b1);
      rst = 1'b1;
      #1;
      chk("rst_abort", {busy, sram_CS, sram_WEB}, {1'b0, 1'b0, 8'hFF});
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      idle(3);
      chk("rst_mem_kept", mem[11], saved);

      // Random phase.
      for (int c = 0; c < 1500; c++) begin
         psum_valid = ($urandom_range(0, 9) < 7);
         psum_first = $urandom_range(0, 1) == 1;
         psum_addr  = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, NW - 1)) : 9'($urandom_range(0, 7));
         psum_mask  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         psum_data  = rnd_word();
         start      = ($urandom_range(0, 29) == 0);
         cfg_len    = 10'($urandom_range(0, 5));
         @(negedge clk);
      end
      start = 1'b0;
      idle(5);
      nmis = 0;
      for (int a = 0; a < NW; a++) if (mem[a] !== golden[a]) nmis++;
      chk("mem_final", 32'(nmis), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
